// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: carries decode operands, register addresses and control into EX,
// with flush/bubble/hold handling and a saturating count of inserted bubbles.
module id_ex_pipeline_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 10,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Bubble,
    input  logic                      Flush,
    input  logic                      Enable,
    input  logic [DATA_WIDTH-1:0]     ID_PC4,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
    input  logic [DATA_WIDTH-1:0]     ID_Immediate,
    input  logic [REG_ADDR_WIDTH-1:0] ID_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] ID_Rt,
    input  logic [REG_ADDR_WIDTH-1:0] ID_Rd,
    input  logic [CTRL_WIDTH-1:0]     ID_Ctrl,
    output logic [DATA_WIDTH-1:0]     EX_PC4,
    output logic [DATA_WIDTH-1:0]     EX_ReadData1,
    output logic [DATA_WIDTH-1:0]     EX_ReadData2,
    output logic [DATA_WIDTH-1:0]     EX_Immediate,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rs,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rt,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rd,
    output logic [CTRL_WIDTH-1:0]     EX_Ctrl,
    output logic                      EX_Valid,
    output logic                      IDEX_MemRead,
    output logic [REG_ADDR_WIDTH-1:0] IDEX_Rt,
    output logic [COUNT_WIDTH-1:0]    BubbleCount
);

    localparam int MEMREAD_BIT = 7;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // ID -> EX stage boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            EX_PC4       <= '0;
            EX_ReadData1 <= '0;
            EX_ReadData2 <= '0;
            EX_Immediate <= '0;
            EX_Rs        <= '0;
            EX_Rt        <= '0;
            EX_Rd        <= '0;
            EX_Ctrl      <= '0;
            EX_Valid     <= 1'b0;
            BubbleCount  <= '0;
        end else if (Flush) begin
            EX_PC4       <= '0;
            EX_ReadData1 <= '0;
            EX_ReadData2 <= '0;
            EX_Immediate <= '0;
            EX_Rs        <= '0;
            EX_Rt        <= '0;
            EX_Rd        <= '0;
            EX_Ctrl      <= '0;
            EX_Valid     <= 1'b0;
        end else if (Bubble) begin
            // Operands still advance so forwarding/hazard logic sees consistent addresses;
            // only the control word is killed. Takes effect even during a global hold.
            EX_PC4       <= ID_PC4;
            EX_ReadData1 <= ID_ReadData1;
            EX_ReadData2 <= ID_ReadData2;
            EX_Immediate <= ID_Immediate;
            EX_Rs        <= ID_Rs;
            EX_Rt        <= ID_Rt;
            EX_Rd        <= ID_Rd;
            EX_Ctrl      <= '0;
            EX_Valid     <= 1'b0;
            BubbleCount  <= sat_inc(BubbleCount);
        end else if (Enable) begin
            EX_PC4       <= ID_PC4;
            EX_ReadData1 <= ID_ReadData1;
            EX_ReadData2 <= ID_ReadData2;
            EX_Immediate <= ID_Immediate;
            EX_Rs        <= ID_Rs;
            EX_Rt        <= ID_Rt;
            EX_Rd        <= ID_Rd;
            EX_Ctrl      <= ID_Ctrl;
            EX_Valid     <= 1'b1;
        end
    end

    assign IDEX_MemRead = EX_Ctrl[MEMREAD_BIT];
    assign IDEX_Rt      = EX_Rt;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed vector table, async-reset and saturation
// sequences, then random traffic against a behavioural model of the slot.
module tb_id_ex_pipeline_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        Bubble, Flush, Enable;
    logic [31:0] ID_PC4, ID_ReadData1, ID_ReadData2, ID_Immediate;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
    logic [9:0]  ID_Ctrl;

    logic [31:0] EX_PC4, EX_ReadData1, EX_ReadData2, EX_Immediate;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rd, IDEX_Rt;
    logic [9:0]  EX_Ctrl;
    logic        EX_Valid, IDEX_MemRead;
    logic [15:0] BubbleCount;

    logic [31:0] s_PC4, s_ReadData1, s_ReadData2, s_Immediate;
    logic [4:0]  s_Rs, s_Rt, s_Rd, s_IDEX_Rt;
    logic [9:0]  s_Ctrl;
    logic        s_Valid, s_MemRead;
    logic [3:0]  s_BubbleCount;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_register dut (
        .clk(clk), .reset(reset), .Bubble(Bubble), .Flush(Flush), .Enable(Enable),
        .ID_PC4(ID_PC4), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_Immediate(ID_Immediate), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_Ctrl(ID_Ctrl),
        .EX_PC4(EX_PC4), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
        .EX_Immediate(EX_Immediate), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .EX_Ctrl(EX_Ctrl), .EX_Valid(EX_Valid), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt(IDEX_Rt), .BubbleCount(BubbleCount)
    );

    id_ex_pipeline_register #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .Bubble(Bubble), .Flush(Flush), .Enable(Enable),
        .ID_PC4(ID_PC4), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_Immediate(ID_Immediate), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_Ctrl(ID_Ctrl),
        .EX_PC4(s_PC4), .EX_ReadData1(s_ReadData1), .EX_ReadData2(s_ReadData2),
        .EX_Immediate(s_Immediate), .EX_Rs(s_Rs), .EX_Rt(s_Rt), .EX_Rd(s_Rd),
        .EX_Ctrl(s_Ctrl), .EX_Valid(s_Valid), .IDEX_MemRead(s_MemRead),
        .IDEX_Rt(s_IDEX_Rt), .BubbleCount(s_BubbleCount)
    );

    // Behavioural view of the EX slot
    typedef struct packed {
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ctrl;
        logic        valid;
    } slot_t;

    slot_t m_slot;
    int    m_cnt16, m_cnt4;

    typedef struct {
        logic       flush, bubble, enable;
        logic [9:0] ctrl;
        logic [4:0] rs, rt;
        logic [9:0] e_ctrl;
        logic       e_valid, e_mr;
        logic [4:0] e_rt, e_rs;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic f, input logic b, input logic en,
                                input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [9:0] ec, input logic ev, input logic emr,
                                input logic [4:0] ert, input logic [4:0] ers, input logic [15:0] ecnt);
        vec_t v;
        v.flush = f; v.bubble = b; v.enable = en; v.ctrl = c; v.rs = rs; v.rt = rt;
        v.e_ctrl = ec; v.e_valid = ev; v.e_mr = emr; v.e_rt = ert; v.e_rs = ers; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic slot_t id_slot();
        slot_t s;
        s.pc4 = ID_PC4; s.rd1 = ID_ReadData1; s.rd2 = ID_ReadData2; s.imm = ID_Immediate;
        s.rs = ID_Rs; s.rt = ID_Rt; s.rd = ID_Rd; s.ctrl = ID_Ctrl; s.valid = 1'b1;
        return s;
    endfunction

    task automatic model_edge();
        if (Flush) begin
            m_slot = '0;
        end else if (Bubble) begin
            m_slot = id_slot();
            m_slot.ctrl = '0;
            m_slot.valid = 1'b0;
            m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
            m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
        end else if (Enable) begin
            m_slot = id_slot();
        end
    endtask

    task automatic model_reset();
        m_slot = '0;
        m_cnt16 = 0;
        m_cnt4 = 0;
    endtask

    task automatic check_model(input string name);
        check(name,
              {EX_PC4, EX_ReadData1, EX_ReadData2, EX_Immediate, EX_Rs, EX_Rt, EX_Rd,
               EX_Ctrl, EX_Valid, IDEX_MemRead, IDEX_Rt, BubbleCount},
              {m_slot.pc4, m_slot.rd1, m_slot.rd2, m_slot.imm, m_slot.rs, m_slot.rt, m_slot.rd,
               m_slot.ctrl, m_slot.valid, m_slot.ctrl[7], m_slot.rt, 16'(m_cnt16)});
        check({name, "_cnt4"}, 256'(s_BubbleCount), 256'(m_cnt4));
    endtask

    task automatic drive_random_data();
        ID_PC4 = $urandom(); ID_ReadData1 = $urandom(); ID_ReadData2 = $urandom();
        ID_Immediate = $urandom(); ID_Rd = 5'($urandom());
    endtask

    initial begin
        reset = 1'b0; Bubble = 1'b0; Flush = 1'b0; Enable = 1'b0;
        ID_PC4 = '0; ID_ReadData1 = '0; ID_ReadData2 = '0; ID_Immediate = '0;
        ID_Rs = '0; ID_Rt = '0; ID_Rd = '0; ID_Ctrl = '0;
        model_reset();

        vecs[0]  = mk(0, 0, 1, 10'h3A0, 5'd1,  5'd8,  10'h3A0, 1, 1, 5'd8,  5'd1, 16'd0);
        vecs[1]  = mk(0, 1, 1, 10'h3A0, 5'd8,  5'd3,  10'h000, 0, 0, 5'd3,  5'd8, 16'd1);
        vecs[2]  = mk(0, 0, 1, 10'h022, 5'd2,  5'd4,  10'h022, 1, 0, 5'd4,  5'd2, 16'd1);
        vecs[3]  = mk(1, 1, 1, 10'h3FF, 5'd5,  5'd6,  10'h000, 0, 0, 5'd0,  5'd0, 16'd1);
        vecs[4]  = mk(0, 0, 0, 10'h3FF, 5'd9,  5'd9,  10'h000, 0, 0, 5'd0,  5'd0, 16'd1);
        vecs[5]  = mk(0, 0, 1, 10'h3FF, 5'd9,  5'd10, 10'h3FF, 1, 1, 5'd10, 5'd9, 16'd1);
        vecs[6]  = mk(0, 0, 0, 10'h011, 5'd3,  5'd3,  10'h3FF, 1, 1, 5'd10, 5'd9, 16'd1);
        vecs[7]  = mk(0, 0, 0, 10'h012, 5'd4,  5'd4,  10'h3FF, 1, 1, 5'd10, 5'd9, 16'd1);
        vecs[8]  = mk(0, 0, 0, 10'h013, 5'd5,  5'd5,  10'h3FF, 1, 1, 5'd10, 5'd9, 16'd1);
        vecs[9]  = mk(0, 1, 0, 10'h3FF, 5'd11, 5'd12, 10'h000, 0, 0, 5'd12, 5'd11, 16'd2);
        vecs[10] = mk(1, 0, 0, 10'h3FF, 5'd13, 5'd14, 10'h000, 0, 0, 5'd0,  5'd0, 16'd2);

        repeat (2) @(negedge clk);
        check_model("reset_state");
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_random_data();
            Flush = vecs[i].flush; Bubble = vecs[i].bubble; Enable = vecs[i].enable;
            ID_Ctrl = vecs[i].ctrl; ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {EX_Ctrl, EX_Valid, IDEX_MemRead, IDEX_Rt, EX_Rs, BubbleCount},
                  {vecs[i].e_ctrl, vecs[i].e_valid, vecs[i].e_mr, vecs[i].e_rt, vecs[i].e_rs,
                   vecs[i].e_cnt});
        end

        // Asynchronous reset mid-cycle with all control bits set
        @(negedge clk);
        Flush = 1'b0; Bubble = 1'b0; Enable = 1'b1; ID_Ctrl = 10'h3FF; drive_random_data();
        @(posedge clk);
        #1;
        check("pre_reset_ctrl", 256'(EX_Ctrl), 256'(10'h3FF));
        #2 reset = 1'b0;
        #1;
        check("async_reset",
              {EX_PC4, EX_ReadData1, EX_ReadData2, EX_Immediate, EX_Rs, EX_Rt, EX_Rd,
               EX_Ctrl, EX_Valid, IDEX_MemRead, IDEX_Rt, BubbleCount, s_BubbleCount}, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // 20 consecutive bubbles: 16-bit counter reaches 20, 4-bit counter pins at F
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            Bubble = 1'b1; Enable = 1'b1; ID_Ctrl = 10'h3A0; ID_Rt = 5'd8;
            @(posedge clk);
            #1;
            if (i > 0) check($sformatf("bubble_memread%0d", i), 256'(IDEX_MemRead), 256'(0));
        end
        check("sat_cnt4", 256'(s_BubbleCount), 256'(4'hF));
        check("cnt16_20", 256'(BubbleCount), 256'(16'd20));

        // Random traffic against the model
        @(negedge clk);
        Bubble = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive_random_data();
            ID_Rs = 5'($urandom()); ID_Rt = 5'($urandom()); ID_Ctrl = 10'($urandom());
            Bubble = ($urandom_range(0, 3) == 0);
            Flush  = ($urandom_range(0, 9) == 0);
            Enable = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            model_edge();
            #1;
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
